// File: rtl/counter_checker_if.sv
// Bundle between a counter monitor and its environment: observed counter plus checker status.
// Capture outputs appear only when COUNTER_CHECKER_CAPTURE_EN is defined.
interface counter_checker_if #(
   parameter int WIDTH     = 16,
   parameter int ERR_CNT_W = 8
);
   logic                 en_i;
   logic [WIDTH-1:0]     counter_i;
   logic                 clr_i;
   logic                 locked_o;
   logic                 err_o;
   logic                 err_sticky_o;
   logic [ERR_CNT_W-1:0] err_cnt_o;
   logic [1:0]           state_o;
`ifdef COUNTER_CHECKER_CAPTURE_EN
   logic [WIDTH-1:0]     exp_cap_o;
   logic [WIDTH-1:0]     act_cap_o;

   modport master (
      output en_i, counter_i, clr_i,
      input  locked_o, err_o, err_sticky_o, err_cnt_o, state_o, exp_cap_o, act_cap_o
   );
   modport slave (
      input  en_i, counter_i, clr_i,
      output locked_o, err_o, err_sticky_o, err_cnt_o, state_o, exp_cap_o, act_cap_o
   );
`else
   modport master (
      output en_i, counter_i, clr_i,
      input  locked_o, err_o, err_sticky_o, err_cnt_o, state_o
   );
   modport slave (
      input  en_i, counter_i, clr_i,
      output locked_o, err_o, err_sticky_o, err_cnt_o, state_o
   );
`endif
endinterface

// File: rtl/counter_checker.sv
// Monitor for a free-running up-counter: checks each sample is the previous one plus the enable.
// Optional first-error capture of expected/actual values under COUNTER_CHECKER_CAPTURE_EN.
module counter_checker #(
   parameter int WIDTH     = 16,
   parameter int ERR_CNT_W = 8,
   parameter int LOCK_LEN  = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   counter_checker_if.slave bus
);
   localparam int RUN_W = $clog2(LOCK_LEN + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SYNC   = 2'b01,
      LOCKED = 2'b10
   } state_t;

   state_t               state_q, state_d;
   logic [RUN_W-1:0]     run_q, run_d, run_inc;
   logic [WIDTH-1:0]     cnt_q, cnt_d, exp_w;
   logic                 en_q, en_d;
   logic                 err_q, err_d;
   logic                 sticky_q, sticky_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 match_w;
`ifdef COUNTER_CHECKER_CAPTURE_EN
   logic [WIDTH-1:0]     exp_cap_q, exp_cap_d;
   logic [WIDTH-1:0]     act_cap_q, act_cap_d;
`endif

   // Expected value wraps naturally at 2^WIDTH.
   assign exp_w   = cnt_q + {{(WIDTH-1){1'b0}}, en_q};
   assign match_w = (bus.counter_i == exp_w);
   assign run_inc = run_q + RUN_W'(1);

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      cnt_d     = bus.counter_i;
      en_d      = bus.en_i;
      err_d     = 1'b0;
      sticky_d  = sticky_q;
      err_cnt_d = err_cnt_q;
`ifdef COUNTER_CHECKER_CAPTURE_EN
      exp_cap_d = exp_cap_q;
      act_cap_d = act_cap_q;
`endif
      if (bus.clr_i) begin
         state_d   = IDLE;
         run_d     = '0;
         cnt_d     = '0;
         en_d      = 1'b0;
         sticky_d  = 1'b0;
         err_cnt_d = '0;
`ifdef COUNTER_CHECKER_CAPTURE_EN
         exp_cap_d = '0;
         act_cap_d = '0;
`endif
      end else begin
         case (state_q)
            IDLE: state_d = SYNC;
            SYNC: begin
               if (!match_w) begin
                  run_d = '0;
               end else if (run_inc == RUN_W'(LOCK_LEN)) begin
                  state_d = LOCKED;
                  run_d   = '0;
               end else begin
                  run_d = run_inc;
               end
            end
            LOCKED: begin
               if (!match_w) begin
                  err_d    = 1'b1;
                  sticky_d = 1'b1;
                  run_d    = '0;
                  state_d  = SYNC;
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
`ifdef COUNTER_CHECKER_CAPTURE_EN
                  // Only the first error since reset/clear is kept.
                  if (!sticky_q) begin
                     exp_cap_d = exp_w;
                     act_cap_d = bus.counter_i;
                  end
`endif
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         run_q     <= '0;
         cnt_q     <= '0;
         en_q      <= 1'b0;
         err_q     <= 1'b0;
         sticky_q  <= 1'b0;
         err_cnt_q <= '0;
`ifdef COUNTER_CHECKER_CAPTURE_EN
         exp_cap_q <= '0;
         act_cap_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         cnt_q     <= cnt_d;
         en_q      <= en_d;
         err_q     <= err_d;
         sticky_q  <= sticky_d;
         err_cnt_q <= err_cnt_d;
`ifdef COUNTER_CHECKER_CAPTURE_EN
         exp_cap_q <= exp_cap_d;
         act_cap_q <= act_cap_d;
`endif
      end
   end

   assign bus.locked_o     = (state_q == LOCKED);
   assign bus.err_o        = err_q;
   assign bus.err_sticky_o = sticky_q;
   assign bus.err_cnt_o    = err_cnt_q;
   assign bus.state_o      = state_q;
`ifdef COUNTER_CHECKER_CAPTURE_EN
   assign bus.exp_cap_o    = exp_cap_q;
   assign bus.act_cap_o    = act_cap_q;
`endif
endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker: vector table, directed corner sequences and
// randomized traffic against a behavioural model. Honours COUNTER_CHECKER_CAPTURE_EN.
module tb_counter_checker;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   counter_checker_if #(.WIDTH(16), .ERR_CNT_W(8)) bus_if ();

   counter_checker #(.WIDTH(16), .ERR_CNT_W(8), .LOCK_LEN(2)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus_if.slave)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: mode 0 idle, 1 acquiring, 2 locked.
   int m_mode, m_run, m_prev, m_pen, m_err, m_sticky, m_errs, m_capx, m_capa;

   typedef struct {
      logic en;
      int   cnt;
      int   st;
      int   lk;
      int   er;
      int   sk;
      int   ec;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode = 0; m_run = 0; m_prev = 0; m_pen = 0; m_err = 0;
      m_sticky = 0; m_errs = 0; m_capx = 0; m_capa = 0;
   endfunction

   function automatic void model_step(input logic en, input int cnt, input logic clr);
      int  c;
      int  expv;
      c    = cnt & 'hFFFF;
      expv = (m_prev + m_pen) % 65536;
      m_err = 0;
      if (clr) begin
         model_reset();
         return;
      end
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (c == expv) begin
            m_run = m_run + 1;
            if (m_run >= 2) begin
               m_mode = 2;
               m_run  = 0;
            end
         end else begin
            m_run = 0;
         end
      end else if (c != expv) begin
         m_err = 1;
         if (m_sticky == 0) begin
            m_capx = expv;
            m_capa = c;
         end
         m_sticky = 1;
         m_errs   = (m_errs < 255) ? m_errs + 1 : 255;
         m_run    = 0;
         m_mode   = 1;
      end
      m_prev = c;
      m_pen  = en ? 1 : 0;
   endfunction

   task automatic check_model();
      chk("state", int'(bus_if.state_o), m_mode);
      chk("locked", int'(bus_if.locked_o), (m_mode == 2) ? 1 : 0);
      chk("err", int'(bus_if.err_o), m_err);
      chk("sticky", int'(bus_if.err_sticky_o), m_sticky);
      chk("err_cnt", int'(bus_if.err_cnt_o), m_errs);
`ifdef COUNTER_CHECKER_CAPTURE_EN
      chk("exp_cap", int'(bus_if.exp_cap_o), m_capx);
      chk("act_cap", int'(bus_if.act_cap_o), m_capa);
`endif
   endtask

   // Drive one sample, clock it in, then compare outputs against the model.
   task automatic apply(input logic en, input int cnt, input logic clr);
      bus_if.en_i      = en;
      bus_if.counter_i = 16'(cnt & 'hFFFF);
      bus_if.clr_i     = clr;
      @(posedge clk_i);
      #1;
      model_step(en, cnt, clr);
      check_model();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_state"}, int'(bus_if.state_o), 0);
      chk({tag, "_locked"}, int'(bus_if.locked_o), 0);
      chk({tag, "_err"}, int'(bus_if.err_o), 0);
      chk({tag, "_sticky"}, int'(bus_if.err_sticky_o), 0);
      chk({tag, "_errcnt"}, int'(bus_if.err_cnt_o), 0);
`ifdef COUNTER_CHECKER_CAPTURE_EN
      chk({tag, "_expcap"}, int'(bus_if.exp_cap_o), 0);
      chk({tag, "_actcap"}, int'(bus_if.act_cap_o), 0);
`endif
   endtask

   initial begin
      int c;
      int last_cnt;
      logic last_en;
      logic en_r;
      int cnt_r;
      logic clr_r;

      // en, cnt, state, locked, err, sticky, err_cnt (outputs after the edge)
      tbl[0] = '{1'b1, 0, 1, 0, 0, 0, 0};
      tbl[1] = '{1'b1, 1, 1, 0, 0, 0, 0};
      tbl[2] = '{1'b1, 2, 2, 1, 0, 0, 0};
      tbl[3] = '{1'b1, 3, 2, 1, 0, 0, 0};
      tbl[4] = '{1'b1, 4, 2, 1, 0, 0, 0};
      tbl[5] = '{1'b1, 5, 2, 1, 0, 0, 0};
      tbl[6] = '{1'b0, 6, 2, 1, 0, 0, 0};
      tbl[7] = '{1'b0, 6, 2, 1, 0, 0, 0};
      tbl[8] = '{1'b1, 6, 2, 1, 0, 0, 0};
      tbl[9] = '{1'b1, 7, 2, 1, 0, 0, 0};

      bus_if.en_i      = 1'b0;
      bus_if.counter_i = '0;
      bus_if.clr_i     = 1'b0;
      model_reset();
      #12;
      check_all_zero("reset");
      @(negedge clk_i);
      rst_i = 1'b0;

      // Lock acquisition, enable toggling with held counter.
      for (int i = 0; i < 10; i++) begin
         apply(tbl[i].en, tbl[i].cnt, 1'b0);
         chk($sformatf("tbl%0d_state", i), int'(bus_if.state_o), tbl[i].st);
         chk($sformatf("tbl%0d_locked", i), int'(bus_if.locked_o), tbl[i].lk);
         chk($sformatf("tbl%0d_err", i), int'(bus_if.err_o), tbl[i].er);
         chk($sformatf("tbl%0d_sticky", i), int'(bus_if.err_sticky_o), tbl[i].sk);
         chk($sformatf("tbl%0d_errcnt", i), int'(bus_if.err_cnt_o), tbl[i].ec);
      end

      // Wrap through 0xFFFF -> 0x0000.
      apply(1'b0, 0, 1'b1);
      check_all_zero("clr_a");
      for (int v = 'hFFFC; v <= 'h10001; v++) begin
         apply(1'b1, v, 1'b0);
         if (v >= 'hFFFE) begin
            chk("wrap_locked", int'(bus_if.locked_o), 1);
            chk("wrap_err", int'(bus_if.err_o), 0);
         end
      end

      // Single injected error and relock.
      apply(1'b0, 0, 1'b1);
      for (int v = 0; v <= 5; v++) apply(1'b1, v, 1'b0);
      chk("pre_err_locked", int'(bus_if.locked_o), 1);
      apply(1'b1, 'h10, 1'b0);
      chk("inj_err", int'(bus_if.err_o), 1);
      chk("inj_cnt", int'(bus_if.err_cnt_o), 1);
      chk("inj_sticky", int'(bus_if.err_sticky_o), 1);
      chk("inj_locked", int'(bus_if.locked_o), 0);
`ifdef COUNTER_CHECKER_CAPTURE_EN
      chk("inj_expcap", int'(bus_if.exp_cap_o), 'h6);
      chk("inj_actcap", int'(bus_if.act_cap_o), 'h10);
`endif
      apply(1'b1, 'h11, 1'b0);
      chk("inj_pulse_end", int'(bus_if.err_o), 0);
      chk("relock_wait", int'(bus_if.locked_o), 0);
      apply(1'b1, 'h12, 1'b0);
      chk("relock", int'(bus_if.locked_o), 1);

      // 300 errors: counter saturates, pulse still fires.
      c = 'h12;
      for (int k = 0; k < 300; k++) begin
         c = c + 5;
         apply(1'b1, c, 1'b0);
         chk("sat_err_pulse", int'(bus_if.err_o), 1);
         c = c + 1;
         apply(1'b1, c, 1'b0);
         c = c + 1;
         apply(1'b1, c, 1'b0);
         chk("sat_relock", int'(bus_if.locked_o), 1);
      end
      chk("sat_errcnt", int'(bus_if.err_cnt_o), 'hFF);

      // Clear while locked with errors logged.
      apply(1'b1, c + 1, 1'b1);
      check_all_zero("clr_b");

      // Asynchronous reset mid-count.
      for (int v = 0; v < 6; v++) apply(1'b1, v, 1'b0);
      apply(1'b1, 'h40, 1'b0);
      #2;
      rst_i = 1'b1;
      #1;
      check_all_zero("async_rst");
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b0;

      // Randomized traffic against the model.
      last_cnt = 0;
      last_en  = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         en_r  = 1'($urandom_range(0, 1));
         clr_r = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 99) < 10) cnt_r = int'($urandom_range(0, 'hFFFF));
         else                            cnt_r = (last_cnt + (last_en ? 1 : 0)) & 'hFFFF;
         if ($urandom_range(0, 199) == 0) cnt_r = 'hFFFF;
         apply(en_r, cnt_r, clr_r);
         last_cnt = cnt_r;
         last_en  = en_r;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
